// File: rtl/exu_load_pkg.sv
// Shared types and constants for the RV32I load execution unit.
// Holds the load FSM state encoding, the LOAD funct3 codes, the ALU
// opcode used for address generation, and small decode helpers.
package exu_load_pkg;

    localparam int ALU_OPC_SIZE = 4;
    localparam logic [ALU_OPC_SIZE-1:0] ALU_ADD = 4'd0;

    typedef enum logic [1:0] {
        LD_IDLE = 2'd0,
        LD_REQ  = 2'd1,
        LD_RSP  = 2'd2
    } load_state_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // True for the five funct3 codes that encode a real RV32I load.
    function automatic logic f3_valid(input logic [2:0] f3);
        logic ok;
        case (f3)
            F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: ok = 1'b1;
            default:                            ok = 1'b0;
        endcase
        return ok;
    endfunction

    // True when the access is not naturally aligned for its size.
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
        logic mis;
        case (f3)
            F3_LH, F3_LHU: mis = a[0];
            F3_LW:         mis = (a != 2'b00);
            default:       mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/exu_load_align.sv
// Load result extraction: selects the byte/half lane from the returned
// aligned word and sign- or zero-extends it according to funct3.
// Misaligned halves/words fall onto the naturally aligned lane.
module exu_load_align
    import exu_load_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      addr_lo,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] wdata
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Pick the byte and halfword lanes addressed by the low address bits.
    always_comb begin
        byte_s = 8'h00;
        case (addr_lo)
            2'b00:   byte_s = rdata[7:0];
            2'b01:   byte_s = rdata[15:8];
            2'b10:   byte_s = rdata[23:16];
            2'b11:   byte_s = rdata[31:24];
            default: byte_s = 8'h00;
        endcase
        if (addr_lo[1]) begin
            half_s = rdata[31:16];
        end else begin
            half_s = rdata[15:0];
        end
    end

    // Extend the selected lane to XLEN as the load type demands.
    always_comb begin
        wdata = {XLEN{1'b0}};
        case (funct3)
            F3_LB:   wdata = {{(XLEN-8){byte_s[7]}}, byte_s};
            F3_LBU:  wdata = {{(XLEN-8){1'b0}}, byte_s};
            F3_LH:   wdata = {{(XLEN-16){half_s[15]}}, half_s};
            F3_LHU:  wdata = {{(XLEN-16){1'b0}}, half_s};
            F3_LW:   wdata = rdata;
            default: wdata = {XLEN{1'b0}};
        endcase
    end

endmodule

// File: rtl/exu_load.sv
// RV32I LOAD execution unit (LB/LH/LW/LBU/LHU).
// Drives address-generation controls to the shared ALU, issues one
// load at a time on the load/store bus and writes the extended result
// to rd. Optional macro EXU_LOAD_MISALIGN_CHK_EN adds a load_misalign
// output and completes misaligned loads without a bus access.
module exu_load
    import exu_load_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int GPR_AW = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load_sel,
    input  logic                    iexec_req_vld,
    input  logic [31:0]             iexec_instr,
    output logic                    iexec_req_rdy,
`ifdef EXU_LOAD_MISALIGN_CHK_EN
    output logic                    load_misalign,
`endif
    output logic [GPR_AW-1:0]       gpr_raddr1,
    input  logic [XLEN-1:0]         gpr_rdata1,
    output logic [GPR_AW-1:0]       gpr_waddr,
    output logic [XLEN-1:0]         gpr_wdata,
    output logic                    gpr_wen,
    output logic [ALU_OPC_SIZE-1:0] alu_opcode,
    output logic [XLEN-1:0]         alu_src1,
    output logic [XLEN-1:0]         alu_src2,
    input  logic [XLEN-1:0]         alu_dst,
    output logic                    ldst_req_vld,
    input  logic                    ldst_req_rdy,
    output logic [XLEN-1:0]         ldst_req_addr,
    output logic                    ldst_req_wen,
    output logic [XLEN-1:0]         ldst_req_wdata,
    input  logic                    ldst_rsp_vld,
    input  logic [XLEN-1:0]         ldst_rsp_rdata
);

    load_state_e       state_r;
    logic [XLEN-1:0]   addr_r;
    logic [GPR_AW-1:0] rd_r;
    logic [2:0]        f3_r;
    logic              req_vld_r;

    logic [2:0]        f3_s;
    logic              accept_s;
    logic              f3_ok_s;
    logic              misalign_s;
    logic              start_s;
    logic              trap_s;
    logic              done_s;
    logic [XLEN-1:0]   ext_data_s;
    logic              unused_opcode_s;

    // Opcode bits are already decoded upstream into load_sel.
    assign unused_opcode_s = ^iexec_instr[6:0];

    assign f3_s     = iexec_instr[14:12];
    assign accept_s = (state_r == LD_IDLE) & iexec_req_vld & load_sel;
    assign f3_ok_s  = f3_valid(f3_s);
`ifdef EXU_LOAD_MISALIGN_CHK_EN
    assign misalign_s    = accept_s & f3_ok_s & is_misaligned(f3_s, alu_dst[1:0]);
    assign load_misalign = misalign_s;
`else
    assign misalign_s    = 1'b0;
`endif
    assign start_s  = accept_s & f3_ok_s & ~misalign_s;
    assign trap_s   = accept_s & (~f3_ok_s | misalign_s);
    assign done_s   = (state_r == LD_RSP) & ldst_rsp_vld;

    // Address generation is always rs1 + sext(imm12) through the ALU.
    assign gpr_raddr1 = iexec_instr[19:15];
    assign alu_opcode = ALU_ADD;
    assign alu_src1   = gpr_rdata1;
    assign alu_src2   = {{(XLEN-12){iexec_instr[31]}}, iexec_instr[31:20]};

    // Completion outputs are only non-zero in the single finishing cycle.
    assign iexec_req_rdy = trap_s | done_s;
    assign gpr_wen       = done_s & (rd_r != {GPR_AW{1'b0}});
    assign gpr_waddr     = done_s ? rd_r : {GPR_AW{1'b0}};
    assign gpr_wdata     = done_s ? ext_data_s : {XLEN{1'b0}};

    assign ldst_req_vld   = req_vld_r;
    assign ldst_req_addr  = req_vld_r ? addr_r : {XLEN{1'b0}};
    assign ldst_req_wen   = 1'b0;
    assign ldst_req_wdata = {XLEN{1'b0}};

    exu_load_align #(
        .XLEN (XLEN)
    ) u_align (
        .rdata   (ldst_rsp_rdata),
        .addr_lo (addr_r[1:0]),
        .funct3  (f3_r),
        .wdata   (ext_data_s)
    );

    // Load FSM: latch the access, hold the request until accepted, await the response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= LD_IDLE;
            addr_r    <= {XLEN{1'b0}};
            rd_r      <= {GPR_AW{1'b0}};
            f3_r      <= 3'b000;
            req_vld_r <= 1'b0;
        end else begin
            case (state_r)
                LD_IDLE: begin
                    if (start_s) begin
                        addr_r    <= alu_dst;
                        rd_r      <= iexec_instr[11:7];
                        f3_r      <= f3_s;
                        req_vld_r <= 1'b1;
                        state_r   <= LD_REQ;
                    end else begin
                        state_r   <= LD_IDLE;
                    end
                end
                LD_REQ: begin
                    if (ldst_req_rdy) begin
                        req_vld_r <= 1'b0;
                        state_r   <= LD_RSP;
                    end else begin
                        state_r   <= LD_REQ;
                    end
                end
                LD_RSP: begin
                    if (ldst_rsp_vld) begin
                        state_r <= LD_IDLE;
                    end else begin
                        state_r <= LD_RSP;
                    end
                end
                default: begin
                    req_vld_r <= 1'b0;
                    state_r   <= LD_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_exu_load.sv
// Self-checking bench for exu_load: scenario tasks drive load
// instructions and a memory bus model; expected writebacks are queued
// when stimulus is driven and popped when the unit completes.
module tb_exu_load;
    import exu_load_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load_sel = 1'b0;
    logic        iexec_req_vld = 1'b0;
    logic [31:0] iexec_instr = 32'h0;
    logic        iexec_req_rdy;
    logic        load_misalign;
    logic [4:0]  gpr_raddr1;
    logic [31:0] gpr_rdata1 = 32'h0;
    logic [4:0]  gpr_waddr;
    logic [31:0] gpr_wdata;
    logic        gpr_wen;
    logic [ALU_OPC_SIZE-1:0] alu_opcode;
    logic [31:0] alu_src1;
    logic [31:0] alu_src2;
    logic [31:0] alu_dst;
    logic        ldst_req_vld;
    logic        ldst_req_rdy = 1'b0;
    logic [31:0] ldst_req_addr;
    logic        ldst_req_wen;
    logic [31:0] ldst_req_wdata;
    logic        ldst_rsp_vld = 1'b0;
    logic [31:0] ldst_rsp_rdata = 32'h0;

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit          bus;
        logic [31:0] addr;
        logic        wen;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        int          lat;
        logic        mis;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    // Environment ALU: adder for the address generation request.
    assign alu_dst = alu_src1 + alu_src2;

`ifndef EXU_LOAD_MISALIGN_CHK_EN
    assign load_misalign = 1'b0;
`endif

    exu_load #(.XLEN(32), .GPR_AW(5)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .load_sel       (load_sel),
        .iexec_req_vld  (iexec_req_vld),
        .iexec_instr    (iexec_instr),
        .iexec_req_rdy  (iexec_req_rdy),
`ifdef EXU_LOAD_MISALIGN_CHK_EN
        .load_misalign  (load_misalign),
`endif
        .gpr_raddr1     (gpr_raddr1),
        .gpr_rdata1     (gpr_rdata1),
        .gpr_waddr      (gpr_waddr),
        .gpr_wdata      (gpr_wdata),
        .gpr_wen        (gpr_wen),
        .alu_opcode     (alu_opcode),
        .alu_src1       (alu_src1),
        .alu_src2       (alu_src2),
        .alu_dst        (alu_dst),
        .ldst_req_vld   (ldst_req_vld),
        .ldst_req_rdy   (ldst_req_rdy),
        .ldst_req_addr  (ldst_req_addr),
        .ldst_req_wen   (ldst_req_wen),
        .ldst_req_wdata (ldst_req_wdata),
        .ldst_rsp_vld   (ldst_rsp_vld),
        .ldst_rsp_rdata (ldst_rsp_rdata)
    );

    function automatic logic [31:0] enc(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
        return {imm, rs1, f3, rd, 7'b0000011};
    endfunction

    function automatic exp_t mk(input bit bus, input logic [31:0] addr, input logic wen,
                                input logic [4:0] waddr, input logic [31:0] wdata,
                                input int lat, input logic mis);
        exp_t e;
        e.bus = bus; e.addr = addr; e.wen = wen; e.waddr = waddr;
        e.wdata = wdata; e.lat = lat; e.mis = mis;
        return e;
    endfunction

    // Drive one load and play the bus; compare the completion against the queued expectation.
    task automatic run_load(input string name, input logic [31:0] instr, input logic [31:0] rs1v,
                            input logic [31:0] rdata, input int req_wait, input int rsp_wait,
                            input bit spur, input exp_t e);
        exp_t ex;
        int   c;
        int   rc;
        int   sc;
        int   wens;
        bit   in_rsp;
        bit   seen_req;
        bit   fin;
        exp_q.push_back(e);
        c = 0; rc = 0; sc = 0; wens = 0; in_rsp = 0; seen_req = 0; fin = 0;
        while (!fin && c < 40) begin
            @(negedge clk);
            iexec_req_vld = 1'b1; load_sel = 1'b1; iexec_instr = instr; gpr_rdata1 = rs1v;
            ldst_req_rdy = 1'b0; ldst_rsp_vld = 1'b0; ldst_rsp_rdata = 32'h0;
            if (ldst_req_vld) begin
                seen_req = 1'b1;
                total++;
                if (ldst_req_addr !== e.addr) begin
                    bad++;
                    $display("FAIL %s req_addr: got %h want %h (cycle %0d)", name, ldst_req_addr, e.addr, c);
                end
                if (rc == req_wait) begin
                    ldst_req_rdy = 1'b1;
                end else if (spur) begin
                    ldst_rsp_vld = 1'b1; ldst_rsp_rdata = 32'hBAD0BAD0;
                end
                rc++;
            end else if (in_rsp) begin
                if (sc == rsp_wait) begin
                    ldst_rsp_vld = 1'b1; ldst_rsp_rdata = rdata;
                end
                sc++;
            end
            #1;
            if (gpr_wen === 1'b1) wens++;
            if (iexec_req_rdy === 1'b1) begin
                fin = 1'b1;
                ex = exp_q.pop_front();
                total++;
                if (c != ex.lat) begin
                    bad++;
                    $display("FAIL %s latency: got %0d want %0d", name, c, ex.lat);
                end
                total++;
                if (seen_req != ex.bus) begin
                    bad++;
                    $display("FAIL %s bus_access: got %0d want %0d", name, seen_req, ex.bus);
                end
                total++;
                if (load_misalign !== ex.mis) begin
                    bad++;
                    $display("FAIL %s misalign: got %b want %b", name, load_misalign, ex.mis);
                end
                if (ex.bus) begin
                    total++;
                    if (gpr_waddr !== ex.waddr) begin
                        bad++;
                        $display("FAIL %s waddr: got %0d want %0d", name, gpr_waddr, ex.waddr);
                    end
                    total++;
                    if (gpr_wdata !== ex.wdata) begin
                        bad++;
                        $display("FAIL %s wdata: got %h want %h", name, gpr_wdata, ex.wdata);
                    end
                end
                total++;
                if (wens != int'(ex.wen)) begin
                    bad++;
                    $display("FAIL %s gpr_wen_count: got %0d want %0d", name, wens, ex.wen);
                end
            end
            if (ldst_req_vld && ldst_req_rdy) in_rsp = 1'b1;
            c++;
        end
        if (!fin) begin
            total++; bad++;
            $display("FAIL %s timeout: got no completion want completion within 40 cycles", name);
            void'(exp_q.pop_front());
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        #1;
        total++;
        if ({iexec_req_rdy, gpr_wen, ldst_req_vld, ldst_req_wen} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_ctrl: got %b want 0000", {iexec_req_rdy, gpr_wen, ldst_req_vld, ldst_req_wen});
        end
        total++;
        if ({gpr_waddr, gpr_wdata, ldst_req_addr, ldst_req_wdata} !== 101'h0) begin
            bad++;
            $display("FAIL reset_data: got waddr=%h wdata=%h addr=%h wd=%h want 0", gpr_waddr, gpr_wdata, ldst_req_addr, ldst_req_wdata);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_lw();
        run_load("lw", enc(12'd4, 5'd2, F3_LW, 5'd5), 32'h1000, 32'hDEADBEEF, 0, 0, 1'b0,
                 mk(1'b1, 32'h1004, 1'b1, 5'd5, 32'hDEADBEEF, 2, 1'b0));
    endtask

    task automatic test_lb_lbu();
        run_load("lb", enc(12'd3, 5'd0, F3_LB, 5'd6), 32'h0, 32'h80112233, 0, 0, 1'b0,
                 mk(1'b1, 32'h3, 1'b1, 5'd6, 32'hFFFFFF80, 2, 1'b0));
        run_load("lbu", enc(12'd3, 5'd0, F3_LBU, 5'd6), 32'h0, 32'h80112233, 0, 0, 1'b0,
                 mk(1'b1, 32'h3, 1'b1, 5'd6, 32'h00000080, 2, 1'b0));
    endtask

    task automatic test_byte_lanes();
        logic [31:0] lane_exp [4];
        lane_exp[0] = 32'h00000033; lane_exp[1] = 32'h00000022;
        lane_exp[2] = 32'h00000011; lane_exp[3] = 32'hFFFFFF80;
        for (int i = 0; i < 4; i++) begin
            run_load("lb_lane", enc(12'(i), 5'd1, F3_LB, 5'd10), 32'h40, 32'h80112233, 0, 0, 1'b0,
                     mk(1'b1, 32'h40 + 32'(i), 1'b1, 5'd10, lane_exp[i], 2, 1'b0));
        end
    endtask

    task automatic test_lh();
        @(negedge clk);
        iexec_req_vld = 1'b0; load_sel = 1'b1;
        iexec_instr = enc(12'hFFE, 5'd3, F3_LH, 5'd7); gpr_rdata1 = 32'h2002;
        #1;
        total++;
        if (alu_src2 !== 32'hFFFFFFFE || alu_src1 !== 32'h2002) begin
            bad++;
            $display("FAIL lh_operands: got src1=%h src2=%h want 00002002 fffffffe", alu_src1, alu_src2);
        end
        total++;
        if (gpr_raddr1 !== 5'd3 || alu_opcode !== ALU_ADD || iexec_req_rdy !== 1'b0) begin
            bad++;
            $display("FAIL lh_ctrl: got raddr=%0d opc=%0d rdy=%b want 3 %0d 0", gpr_raddr1, alu_opcode, iexec_req_rdy, ALU_ADD);
        end
        run_load("lh_lo", enc(12'hFFE, 5'd3, F3_LH, 5'd7), 32'h2002, 32'h80017FFF, 0, 0, 1'b0,
                 mk(1'b1, 32'h2000, 1'b1, 5'd7, 32'h00007FFF, 2, 1'b0));
        run_load("lh_hi", enc(12'hFFE, 5'd3, F3_LH, 5'd7), 32'h2004, 32'h80017FFF, 0, 0, 1'b0,
                 mk(1'b1, 32'h2002, 1'b1, 5'd7, 32'hFFFF8001, 2, 1'b0));
        run_load("lhu_hi", enc(12'hFFE, 5'd3, F3_LHU, 5'd7), 32'h2004, 32'h80017FFF, 0, 0, 1'b0,
                 mk(1'b1, 32'h2002, 1'b1, 5'd7, 32'h00008001, 2, 1'b0));
    endtask

    task automatic test_backpressure();
        run_load("backpressure", enc(12'd0, 5'd1, F3_LW, 5'd9), 32'h3000, 32'h12345678, 3, 2, 1'b1,
                 mk(1'b1, 32'h3000, 1'b1, 5'd9, 32'h12345678, 7, 1'b0));
    endtask

    task automatic test_x0_and_bad_f3();
        logic [2:0] bad_f3 [3];
        bad_f3[0] = 3'b011; bad_f3[1] = 3'b110; bad_f3[2] = 3'b111;
        run_load("rd_x0", enc(12'd8, 5'd1, F3_LW, 5'd0), 32'h100, 32'hA5A5A5A5, 0, 0, 1'b0,
                 mk(1'b1, 32'h108, 1'b0, 5'd0, 32'hA5A5A5A5, 2, 1'b0));
        for (int i = 0; i < 3; i++) begin
            run_load("bad_f3", enc(12'd0, 5'd1, bad_f3[i], 5'd4), 32'h100, 32'h0, 0, 0, 1'b0,
                     mk(1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 0, 1'b0));
        end
    endtask

    task automatic test_misalign();
`ifdef EXU_LOAD_MISALIGN_CHK_EN
        run_load("lw_mis", enc(12'd1, 5'd2, F3_LW, 5'd5), 32'h1000, 32'h11223344, 0, 0, 1'b0,
                 mk(1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 0, 1'b1));
        run_load("lh_mis", enc(12'd3, 5'd2, F3_LH, 5'd5), 32'h1000, 32'hA5A50102, 0, 0, 1'b0,
                 mk(1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 0, 1'b1));
`else
        run_load("lw_mis", enc(12'd1, 5'd2, F3_LW, 5'd5), 32'h1000, 32'h11223344, 0, 0, 1'b0,
                 mk(1'b1, 32'h1001, 1'b1, 5'd5, 32'h11223344, 2, 1'b0));
        run_load("lh_mis", enc(12'd3, 5'd2, F3_LH, 5'd5), 32'h1000, 32'hA5A50102, 0, 0, 1'b0,
                 mk(1'b1, 32'h1003, 1'b1, 5'd5, 32'hFFFFA5A5, 2, 1'b0));
`endif
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        iexec_req_vld = 1'b1; load_sel = 1'b1; iexec_instr = enc(12'd0, 5'd1, F3_LW, 5'd12);
        gpr_rdata1 = 32'h500; ldst_req_rdy = 1'b0; ldst_rsp_vld = 1'b0;
        @(negedge clk);
        ldst_req_rdy = 1'b1;
        @(negedge clk);
        ldst_req_rdy = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({ldst_req_vld, iexec_req_rdy, gpr_wen} !== 3'b000) begin
            bad++;
            $display("FAIL rst_mid_outputs: got %b want 000", {ldst_req_vld, iexec_req_rdy, gpr_wen});
        end
        ldst_rsp_vld = 1'b1; ldst_rsp_rdata = 32'hCAFEF00D;
        #1;
        total++;
        if ({iexec_req_rdy, gpr_wen} !== 2'b00 || gpr_wdata !== 32'h0) begin
            bad++;
            $display("FAIL rst_mid_in_reset: got rdy=%b wen=%b wdata=%h want 0 0 0", iexec_req_rdy, gpr_wen, gpr_wdata);
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            rst_n = 1'b1; iexec_req_vld = 1'b0;
            #1;
            total++;
            if ({iexec_req_rdy, gpr_wen, ldst_req_vld} !== 3'b000 || gpr_wdata !== 32'h0) begin
                bad++;
                $display("FAIL rst_mid_late_rsp: got rdy=%b wen=%b vld=%b wdata=%h want 0 0 0 0", iexec_req_rdy, gpr_wen, ldst_req_vld, gpr_wdata);
            end
        end
        @(negedge clk);
        ldst_rsp_vld = 1'b0; ldst_rsp_rdata = 32'h0;
        run_load("after_rst", enc(12'd4, 5'd1, F3_LW, 5'd13), 32'h600, 32'h0BADF00D, 0, 0, 1'b0,
                 mk(1'b1, 32'h604, 1'b1, 5'd13, 32'h0BADF00D, 2, 1'b0));
    endtask

    initial begin
        test_reset();
        test_lw();
        test_lb_lbu();
        test_byte_lanes();
        test_lh();
        test_backpressure();
        test_x0_and_bad_f3();
        test_misalign();
        test_reset_mid();
        @(negedge clk);
        iexec_req_vld = 1'b0; load_sel = 1'b0;
        ldst_req_rdy = 1'b0; ldst_rsp_vld = 1'b0;
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
